video_dvi_encoder: RTL and testbench
====================================

Name: video_dvi_encoder

Overview:
Consumes the registered 640x480@60 pixel stream from the VGA timing stage: 4-bit R/G/B, sync pins and the active flag. It produces three 10-bit TMDS symbols per pixel clock, one each for blue (channel 0), green (channel 1) and red (channel 2), for a downstream serializer/DVI PHY. The block expands colour depth, performs DVI 1.0 8b/10b TMDS encoding with running-disparity tracking, and emits control symbols during blanking.

Parameters:
SYNC_INVERT, 0, 1 = invert vid_hsync/vid_vsync before they are placed on channel-0 control bits; 0 = pass pin levels unchanged.

Ports:
clk  in  1  pixel clock, 25 MHz domain shared with the timing stage
rst  in  1  asynchronous, active-high reset
vid_r  in  4  red; valid when vid_active=1
vid_g  in  4  green
vid_b  in  4  blue
vid_hsync  in  1  hsync pin level, active-low as driven upstream
vid_vsync  in  1  vsync pin level
vid_active  in  1  display-enable; 1 = pixel data, 0 = blanking
tmds_ch0  out  10  blue symbol, bit 0 transmitted first
tmds_ch1  out  10  green symbol
tmds_ch2  out  10  red symbol

Behaviour:
- Reset: all tmds_chN = 10'b1101010100 (control 00). All pipeline registers and disparity counters = 0. Applies immediately, asynchronously. First post-reset symbol is computed from inputs sampled after reset deasserts.
- Latency: exactly 2 clk from input sample to symbol, for data and control alike; no bubbles; one symbol per clk per channel.
- Stage 1 (registered):
  - Expand each 4-bit colour c to 8-bit D = {c,c}.
  - n1 = popcount(D).
  - If n1>4 or (n1==4 and D[0]==0): XNOR chain, q_m[0]=D[0], q_m[i]=q_m[i-1] XNOR D[i], q_m[8]=0.
  - Else: XOR chain, q_m[8]=1.
  - Register q_m[8:0], de, c0, c1 per channel.
- Stage 2 (registered): per channel, signed 5-bit cnt; N1/N0 = ones/zeros of q_m[7:0].
  - de=0: output control symbol per {c1,c0}: 00 -> 1101010100, 01 -> 0010101011, 10 -> 0101010100, 11 -> 1010101011. Force cnt to 0.
  - de=1, cnt==0 or N1==N0: out = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]}.
    - cnt += q_m[8] ? (N1-N0) : (N0-N1).
  - de=1, (cnt>0 and N1>N0) or (cnt<0 and N0>N1): out = {1, q_m[8], ~q_m[7:0]}.
    - cnt += 2*q_m[8] + (N0-N1).
  - Otherwise: out = {0, q_m[8], q_m[7:0]}.
    - cnt += -2*(~q_m[8]) + (N1-N0).
- Control bits:
  - ch0: c0 = vid_hsync ^ SYNC_INVERT, c1 = vid_vsync ^ SYNC_INVERT.
  - ch1 and ch2: c0 = c1 = 0.
- Disparity: |cnt| ≤ 10 at all times; 5-bit signed width has no wrap. Arithmetic is done in 6-bit signed and truncated only after the result is proven in range.
- Active-to-blank transition: the first blanking symbol is a control symbol and cnt is zeroed in the same cycle. The first active pixel after blanking starts with cnt=0.
- Reset mid-line: output returns to the reset symbol at once. The encoder resynchronises purely from vid_active; no frame state is kept.

Decomposition:
- Shared package video_dvi_pkg:
  - CTRL_00..CTRL_11 10-bit constants
  - RESET_SYMBOL
  - CNT_W = 5
  - popcount8 function
- One natural sub-module: tmds_channel_encoder (clk, rst, D[7:0], de, c0, c1 -> q_out[9:0]), containing both stages and its own cnt. Instantiated three times by video_dvi_encoder, which also does the 4->8 expansion and sync mapping.

Test Plan:
- Reset: assert rst mid-stream -> all channels = 1101010100 within the same cycle. Hold rst low 2 clk with vid_active=0, hsync=vsync=1 -> ch0 = 1010101011, ch1 = ch2 = 1101010100.
- Sync mapping: blanking, (hsync,vsync) = (0,1),(1,0),(0,0) -> ch0 = 0101010100, 0010101011, 1101010100. Same with SYNC_INVERT=1 -> bit-inverted mapping; ch1/ch2 unchanged.
- Black run: vid_active=1, vid_b=0 from cnt=0 -> ch0 symbols 0100000000, 1111111111, 0100000000 (cnt -8, +2, -6). Each symbol appears exactly 2 clk after its input.
- White: vid_b=4'hF for one pixel after blanking -> ch0 = 1000000000.
- Disparity reset: 7 pixels of 4'h0 then blanking then 4'h0 -> first post-blank data symbol = 0100000000, independent of prior cnt.
- Random soak: 1 full frame of random pixels with the 800x525 timing pattern. Compare each channel against a reference TMDS model. Check |cnt| ≤ 10 throughout, and that the TMDS decode of every active symbol recovers {c,c}.

Source files
------------

// File: rtl/video_dvi_pkg.sv
// Shared definitions for the DVI TMDS encoder slice.
// Holds the four TMDS control symbols, the reset symbol, the
// running-disparity counter width and a byte popcount helper.
package video_dvi_pkg;

    localparam logic [9:0] CTRL_00      = 10'b1101010100;
    localparam logic [9:0] CTRL_01      = 10'b0010101011;
    localparam logic [9:0] CTRL_10      = 10'b0101010100;
    localparam logic [9:0] CTRL_11      = 10'b1010101011;
    localparam logic [9:0] RESET_SYMBOL = CTRL_00;

    localparam int CNT_W = 5;

    // Number of set bits in a byte (0..8).
    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/video_dvi_if.sv
// Pixel-stream and TMDS-symbol bundle between the VGA timing stage,
// the DVI encoder and the serializer.
//   vid_r/g/b   : 4-bit colour, valid while vid_active=1
//   vid_hsync/vsync : sync pin levels
//   vid_active  : 1 = pixel data, 0 = blanking
//   tmds_ch0..2 : 10-bit symbols (blue, green, red), bit 0 sent first
// master drives pixels and receives symbols; slave is the encoder.
interface video_dvi_if;
    import video_dvi_pkg::*;

    logic [3:0] vid_r;
    logic [3:0] vid_g;
    logic [3:0] vid_b;
    logic       vid_hsync;
    logic       vid_vsync;
    logic       vid_active;
    logic [9:0] tmds_ch0;
    logic [9:0] tmds_ch1;
    logic [9:0] tmds_ch2;

    modport master (
        output vid_r, vid_g, vid_b, vid_hsync, vid_vsync, vid_active,
        input  tmds_ch0, tmds_ch1, tmds_ch2
    );

    modport slave (
        input  vid_r, vid_g, vid_b, vid_hsync, vid_vsync, vid_active,
        output tmds_ch0, tmds_ch1, tmds_ch2
    );

endinterface

// File: rtl/tmds_channel_encoder.sv
// One DVI TMDS channel: 8b/9b transition minimisation (stage 1) and
// DC balancing with running disparity / control symbols (stage 2).
// Two register stages, one symbol per clock.
//   clk, rst : pixel clock, asynchronous active-high reset
//   d        : 8-bit data byte
//   de       : 1 = encode data, 0 = emit control symbol {c1,c0}
//   c0, c1   : control bits used while de=0
//   q_out    : registered 10-bit TMDS symbol
module tmds_channel_encoder
    import video_dvi_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] d,
    input  logic       de,
    input  logic       c0,
    input  logic       c1,
    output logic [9:0] q_out
);

    // q[i] = d[0]^...^d[i]; the XNOR chain is this with every odd bit
    // inverted, which avoids a serial feedback loop in the logic.
    function automatic logic [7:0] prefix_xor8(input logic [7:0] v);
        logic [7:0] p;
        p[0] = v[0];
        for (int i = 1; i < 8; i++) begin
            p[i] = p[i - 1] ^ v[i];
        end
        return p;
    endfunction

    logic [3:0]             n1_s;
    logic                   use_xnor_s;
    logic [8:0]             q_m_s;
    logic [8:0]             q_m_r;
    logic                   de_r;
    logic                   c0_r;
    logic                   c1_r;

    logic [3:0]             n1q_s;
    logic [3:0]             n0q_s;
    logic signed [5:0]      diff_s;
    logic signed [5:0]      cnt_ext_s;
    logic signed [5:0]      two_q8_s;
    logic signed [5:0]      two_nq8_s;
    logic signed [5:0]      cnt_next6_s;
    logic [9:0]             sym_s;
    logic signed [CNT_W-1:0] cnt_r;
    logic [9:0]             q_out_r;
    logic                   unused_cnt_msb_s;

    // Stage 1: choose XOR or XNOR chain to minimise transitions.
    always_comb begin
        n1_s       = popcount8(d);
        use_xnor_s = (n1_s > 4'd4) || ((n1_s == 4'd4) && (d[0] == 1'b0));
        if (use_xnor_s) begin
            q_m_s = {1'b0, prefix_xor8(d) ^ 8'b10101010};
        end else begin
            q_m_s = {1'b1, prefix_xor8(d)};
        end
    end

    // Stage 1 pipeline register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_m_r <= 9'd0;
            de_r  <= 1'b0;
            c0_r  <= 1'b0;
            c1_r  <= 1'b0;
        end else begin
            q_m_r <= q_m_s;
            de_r  <= de;
            c0_r  <= c0;
            c1_r  <= c1;
        end
    end

    assign n1q_s     = popcount8(q_m_r[7:0]);
    assign n0q_s     = 4'd8 - n1q_s;
    assign diff_s    = $signed({2'b00, n1q_s}) - $signed({2'b00, n0q_s});
    assign cnt_ext_s = {cnt_r[CNT_W-1], cnt_r};
    assign two_q8_s  = {4'b0000, q_m_r[8], 1'b0};
    assign two_nq8_s = {4'b0000, ~q_m_r[8], 1'b0};

    // Stage 2: DC balance against the running disparity, or control symbol.
    // All sums are formed 6 bits wide; the disparity never leaves +/-10,
    // so dropping the top bit afterwards cannot wrap.
    always_comb begin
        sym_s       = RESET_SYMBOL;
        cnt_next6_s = 6'sd0;
        if (!de_r) begin
            case ({c1_r, c0_r})
                2'b00:   sym_s = CTRL_00;
                2'b01:   sym_s = CTRL_01;
                2'b10:   sym_s = CTRL_10;
                2'b11:   sym_s = CTRL_11;
                default: sym_s = CTRL_00;
            endcase
            cnt_next6_s = 6'sd0;
        end else if ((cnt_r == 5'sd0) || (n1q_s == n0q_s)) begin
            sym_s = {~q_m_r[8], q_m_r[8], q_m_r[8] ? q_m_r[7:0] : ~q_m_r[7:0]};
            if (q_m_r[8]) begin
                cnt_next6_s = cnt_ext_s + diff_s;
            end else begin
                cnt_next6_s = cnt_ext_s - diff_s;
            end
        end else if (((cnt_r > 5'sd0) && (n1q_s > n0q_s)) ||
                     ((cnt_r < 5'sd0) && (n0q_s > n1q_s))) begin
            sym_s       = {1'b1, q_m_r[8], ~q_m_r[7:0]};
            cnt_next6_s = cnt_ext_s + two_q8_s - diff_s;
        end else begin
            sym_s       = {1'b0, q_m_r[8], q_m_r[7:0]};
            cnt_next6_s = cnt_ext_s - two_nq8_s + diff_s;
        end
    end

    // Top bit of the 6-bit sum is redundant once the range is known.
    assign unused_cnt_msb_s = cnt_next6_s[5];

    // Stage 2 register: output symbol and running disparity.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_out_r <= RESET_SYMBOL;
            cnt_r   <= 5'sd0;
        end else begin
            q_out_r <= sym_s;
            cnt_r   <= cnt_next6_s[CNT_W-1:0];
        end
    end

    assign q_out = q_out_r;

endmodule

// File: rtl/video_dvi_encoder.sv
// DVI encoder for the 640x480@60 pixel stream. Expands 4-bit colour to
// 8 bits by replication, maps sync pins onto the blue channel control
// bits and TMDS-encodes blue/green/red on channels 0/1/2.
//   clk, rst : pixel clock, asynchronous active-high reset
//   bus      : slave side of video_dvi_if (pixels in, symbols out)
// SYNC_INVERT=1 inverts hsync/vsync before they become c0/c1.
module video_dvi_encoder
    import video_dvi_pkg::*;
#(
    parameter bit SYNC_INVERT = 1'b0
)(
    input  logic        clk,
    input  logic        rst,
    video_dvi_if.slave  bus
);

    logic       hs_ctrl_s;
    logic       vs_ctrl_s;
    logic [9:0] ch0_s;
    logic [9:0] ch1_s;
    logic [9:0] ch2_s;

    assign hs_ctrl_s = bus.vid_hsync ^ SYNC_INVERT;
    assign vs_ctrl_s = bus.vid_vsync ^ SYNC_INVERT;

    tmds_channel_encoder u_ch0 (
        .clk   (clk),
        .rst   (rst),
        .d     ({bus.vid_b, bus.vid_b}),
        .de    (bus.vid_active),
        .c0    (hs_ctrl_s),
        .c1    (vs_ctrl_s),
        .q_out (ch0_s)
    );

    tmds_channel_encoder u_ch1 (
        .clk   (clk),
        .rst   (rst),
        .d     ({bus.vid_g, bus.vid_g}),
        .de    (bus.vid_active),
        .c0    (1'b0),
        .c1    (1'b0),
        .q_out (ch1_s)
    );

    tmds_channel_encoder u_ch2 (
        .clk   (clk),
        .rst   (rst),
        .d     ({bus.vid_r, bus.vid_r}),
        .de    (bus.vid_active),
        .c0    (1'b0),
        .c1    (1'b0),
        .q_out (ch2_s)
    );

    assign bus.tmds_ch0 = ch0_s;
    assign bus.tmds_ch1 = ch1_s;
    assign bus.tmds_ch2 = ch2_s;

endmodule

// File: tb/tb_video_dvi_encoder.sv
// Scoreboard bench for video_dvi_encoder: two instances (SYNC_INVERT 0
// and 1) share the stimulus. The driver pushes expected symbols due two
// clocks later; a forked monitor pops and compares on falling edges.
module tb_video_dvi_encoder;

    localparam logic [9:0] S_C00 = 10'b1101010100;
    localparam logic [9:0] S_C01 = 10'b0010101011;
    localparam logic [9:0] S_C10 = 10'b0101010100;
    localparam logic [9:0] S_C11 = 10'b1010101011;
    localparam logic [9:0] S_BLK = 10'b0100000000;
    localparam logic [9:0] S_BLI = 10'b1111111111;
    localparam logic [9:0] S_WHT = 10'b1000000000;
    localparam int LINES = 12;

    typedef struct {
        int         due;
        logic [9:0] e0;
        logic [9:0] e1;
        logic [9:0] e2;
        logic [9:0] einv;
        bit         act;
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   mcnt0 = 0;
    int   mcnt1 = 0;
    int   mcnt2 = 0;
    int   mcnti = 0;
    int   max_abs = 0;
    exp_t sb[$];
    exp_t me;

    video_dvi_if bus0();
    video_dvi_if bus1();

    video_dvi_encoder #(.SYNC_INVERT(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    video_dvi_encoder #(.SYNC_INVERT(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    always #20 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%b expected=%b cyc=%0d", name, act, exp, cyc);
        end
    endtask

    // Reference TMDS encoder, written straight from the algorithm.
    task automatic tmds_ref(input logic [7:0] d, input bit de, input bit c0, input bit c1,
                            input int cin, output int cout, output logic [9:0] sym);
        int n1, ones, zeros;
        bit xn;
        logic [8:0] qm;
        n1 = 0;
        for (int i = 0; i < 8; i++) n1 += int'(d[i]);
        xn = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
        qm[0] = d[0];
        for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
        qm[8] = !xn;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(qm[i]);
        zeros = 8 - ones;
        if (!de) begin
            cout = 0;
            case ({c1, c0})
                2'b00:   sym = S_C00;
                2'b01:   sym = S_C01;
                2'b10:   sym = S_C10;
                default: sym = S_C11;
            endcase
        end else if (cin == 0 || ones == zeros) begin
            sym  = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
            cout = cin + (qm[8] ? ones - zeros : zeros - ones);
        end else if ((cin > 0 && ones > zeros) || (cin < 0 && zeros > ones)) begin
            sym  = {1'b1, qm[8], ~qm[7:0]};
            cout = cin + 2 * int'(qm[8]) + zeros - ones;
        end else begin
            sym  = {1'b0, qm[8], qm[7:0]};
            cout = cin - 2 * (1 - int'(qm[8])) + ones - zeros;
        end
    endtask

    function automatic logic [7:0] tmds_decode(input logic [9:0] s);
        logic [7:0] q, dd;
        q = s[9] ? ~s[7:0] : s[7:0];
        dd[0] = q[0];
        for (int i = 1; i < 8; i++) dd[i] = s[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
        return dd;
    endfunction

    task automatic drive(input logic [3:0] r, input logic [3:0] g, input logic [3:0] b,
                         input bit hs, input bit vs, input bit act,
                         input logic [9:0] h0, input logic [9:0] hinv, input bit use_hand);
        exp_t e;
        int nc;
        @(negedge clk);
        bus0.vid_r = r; bus0.vid_g = g; bus0.vid_b = b;
        bus0.vid_hsync = hs; bus0.vid_vsync = vs; bus0.vid_active = act;
        bus1.vid_r = r; bus1.vid_g = g; bus1.vid_b = b;
        bus1.vid_hsync = hs; bus1.vid_vsync = vs; bus1.vid_active = act;
        tmds_ref({b, b}, act, hs, vs, mcnt0, nc, e.e0);    mcnt0 = nc;
        tmds_ref({g, g}, act, 1'b0, 1'b0, mcnt1, nc, e.e1); mcnt1 = nc;
        tmds_ref({r, r}, act, 1'b0, 1'b0, mcnt2, nc, e.e2); mcnt2 = nc;
        tmds_ref({b, b}, act, ~hs, ~vs, mcnti, nc, e.einv); mcnti = nc;
        if (use_hand) begin
            e.e0   = h0;
            e.einv = hinv;
        end
        if (mcnt0 > max_abs)  max_abs = mcnt0;
        if (-mcnt0 > max_abs) max_abs = -mcnt0;
        if (mcnt1 > max_abs)  max_abs = mcnt1;
        if (-mcnt1 > max_abs) max_abs = -mcnt1;
        if (mcnt2 > max_abs)  max_abs = mcnt2;
        if (-mcnt2 > max_abs) max_abs = -mcnt2;
        e.due = cyc + 2;
        e.act = act;
        e.r = r; e.g = g; e.b = b;
        sb.push_back(e);
    endtask

    task automatic blank(input bit hs, input bit vs, input logic [9:0] h0, input logic [9:0] hinv);
        drive(4'h0, 4'h0, 4'h0, hs, vs, 1'b0, h0, hinv, 1'b1);
    endtask

    task automatic pix_b(input logic [3:0] b, input logic [9:0] h0);
        drive(4'h0, 4'h0, b, 1'b1, 1'b1, 1'b1, h0, h0, 1'b1);
    endtask

    task automatic pix_free(input logic [3:0] b);
        drive(4'h0, 4'h0, b, 1'b1, 1'b1, 1'b1, 10'd0, 10'd0, 1'b0);
    endtask

    task automatic check_reset_symbols(input string tag);
        check({tag, "_ch0"},  bus0.tmds_ch0, S_C00);
        check({tag, "_ch1"},  bus0.tmds_ch1, S_C00);
        check({tag, "_ch2"},  bus0.tmds_ch2, S_C00);
        check({tag, "_inv0"}, bus1.tmds_ch0, S_C00);
    endtask

    task automatic set_idle_inputs();
        bus0.vid_r = 4'h0; bus0.vid_g = 4'h0; bus0.vid_b = 4'h0;
        bus0.vid_hsync = 1'b1; bus0.vid_vsync = 1'b1; bus0.vid_active = 1'b0;
        bus1.vid_r = 4'h0; bus1.vid_g = 4'h0; bus1.vid_b = 4'h0;
        bus1.vid_hsync = 1'b1; bus1.vid_vsync = 1'b1; bus1.vid_active = 1'b0;
    endtask

    initial begin
        set_idle_inputs();

        // Monitor: pops every expectation that falls due this cycle.
        fork
            forever begin
                @(negedge clk);
                if (!rst) begin
                    while (sb.size() > 0 && sb[0].due <= cyc) begin
                        me = sb.pop_front();
                        if (me.due < cyc) begin
                            checks++;
                            failures++;
                            $display("FAIL late_symbol due=%0d now=%0d", me.due, cyc);
                        end else begin
                            check("ch0", bus0.tmds_ch0, me.e0);
                            check("ch1", bus0.tmds_ch1, me.e1);
                            check("ch2", bus0.tmds_ch2, me.e2);
                            check("inv_ch0", bus1.tmds_ch0, me.einv);
                            if (me.act) begin
                                check("dec_b", {2'b00, tmds_decode(bus0.tmds_ch0)}, {2'b00, me.b, me.b});
                                check("dec_g", {2'b00, tmds_decode(bus0.tmds_ch1)}, {2'b00, me.g, me.g});
                                check("dec_r", {2'b00, tmds_decode(bus0.tmds_ch2)}, {2'b00, me.r, me.r});
                            end
                        end
                    end
                end
            end
        join_none

        repeat (3) @(posedge clk);
        #2;
        check_reset_symbols("por");
        @(negedge clk);
        rst = 1'b0;

        // Blanking with both syncs high, then the sync mapping table.
        blank(1'b1, 1'b1, S_C11, S_C00);
        blank(1'b1, 1'b1, S_C11, S_C00);
        blank(1'b0, 1'b1, S_C10, S_C01);
        blank(1'b1, 1'b0, S_C01, S_C10);
        blank(1'b0, 1'b0, S_C00, S_C11);

        // Black run from zero disparity: -8, +2, -6.
        pix_b(4'h0, S_BLK);
        pix_b(4'h0, S_BLI);
        pix_b(4'h0, S_BLK);

        // White pixel right after blanking.
        blank(1'b1, 1'b1, S_C11, S_C00);
        pix_b(4'hF, S_WHT);

        // Disparity is cleared by blanking regardless of history.
        for (int i = 0; i < 7; i++) pix_free(4'h0);
        blank(1'b1, 1'b1, S_C11, S_C00);
        pix_b(4'h0, S_BLK);

        // A few mixed pixels, then reset in the middle of the line.
        for (int i = 0; i < 5; i++) begin
            drive(4'($urandom), 4'($urandom), 4'($urandom), 1'b1, 1'b1, 1'b1, 10'd0, 10'd0, 1'b0);
        end
        @(posedge clk);
        #2;
        rst = 1'b1;
        sb.delete();
        mcnt0 = 0; mcnt1 = 0; mcnt2 = 0; mcnti = 0;
        #1;
        check_reset_symbols("mid_rst");
        set_idle_inputs();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        blank(1'b1, 1'b1, S_C11, S_C00);
        blank(1'b1, 1'b1, S_C11, S_C00);

        // Random pixels over several lines of the 800-clock line timing.
        for (int y = 0; y < LINES; y++) begin
            for (int x = 0; x < 800; x++) begin
                drive(4'($urandom), 4'($urandom), 4'($urandom),
                      !(x >= 656 && x < 752), !(y == 1 || y == 2),
                      (x < 640) && (y >= 3), 10'd0, 10'd0, 1'b0);
            end
        end

        repeat (4) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d expected=0", sb.size());
        end
        checks++;
        if (max_abs > 10) begin
            failures++;
            $display("FAIL disparity_bound max=%0d limit=10", max_abs);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
